// File: rtl/rng_pkg.sv
// Shared types and constants for the round-robin random-byte scheduler.
// Optional feature macro used by rng_sched: RNG_SEED_LOAD_EN.
package rng_pkg;

   localparam int unsigned RNG_W = 8;
   localparam logic [RNG_W-1:0] TAP_MASK     = 8'hB8;
   localparam logic [RNG_W-1:0] DEFAULT_SEED = 8'h0F;

   typedef enum logic [1:0] {
      FILL,
      HOLD,
      GRANT
   } state_t;

   // Fibonacci step: XOR of the tapped bits is shifted in at bit 0.
   function automatic logic [RNG_W-1:0] lfsr_next(input logic [RNG_W-1:0] v);
      return {v[RNG_W-2:0], ^(v & TAP_MASK)};
   endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR register with step enable and seed load.
// A zero load value is replaced by SEED so the register never locks up.
module lfsr8
   import rng_pkg::*;
#(
   parameter logic [RNG_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_step,
   input  logic             i_load,
   input  logic [RNG_W-1:0] i_load_val,
   output logic [RNG_W-1:0] o_value
);

   logic [RNG_W-1:0] r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else if (i_load) begin
         r_lfsr <= (i_load_val == '0) ? SEED : i_load_val;
      end else if (i_step) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign o_value = r_lfsr;

endmodule

// File: rtl/rng_sched.sv
// Round-robin scheduler sharing one LFSR byte stream among NREQ requesters.
// Optional feature macro: RNG_SEED_LOAD_EN (adds seed_we/seed reload ports).
module rng_sched
   import rng_pkg::*;
#(
   parameter int unsigned      NREQ  = 4,
   parameter int unsigned      STEPS = 14,
   parameter logic [RNG_W-1:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [RNG_W-1:0] rdata,
   output logic             busy
`ifdef RNG_SEED_LOAD_EN
   ,
   input  logic             seed_we,
   input  logic [RNG_W-1:0] seed
`endif
);

   localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0]  LAST = 8'(STEPS - 1);

   state_t           r_state;
   logic [7:0]       r_cnt;
   logic [IW-1:0]    r_ptr;
   logic [NREQ-1:0]  r_gnt;
   logic [RNG_W-1:0] r_rdata;
   logic             r_busy;

   logic [RNG_W-1:0] w_lfsr;
   logic             w_step;
   logic             w_load;
   logic [RNG_W-1:0] w_load_val;
   logic             w_found;
   logic [IW-1:0]    w_idx;
   logic [IW-1:0]    w_win;
   logic [IW-1:0]    w_ptr_nxt;
   logic [NREQ-1:0]  w_onehot;

`ifdef RNG_SEED_LOAD_EN
   assign w_load     = seed_we;
   assign w_load_val = seed;
`else
   assign w_load     = 1'b0;
   assign w_load_val = '0;
`endif

   // The GRANT cycle already performs the first shift of the next fill.
   assign w_step = !w_load && (r_state == FILL || r_state == GRANT);

   lfsr8 #(
      .SEED(SEED)
   ) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_step     (w_step),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_value    (w_lfsr)
   );

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_idx = IW'((32'(r_ptr) + k) % NREQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_ptr_nxt = IW'((32'(w_win) + 1) % NREQ);
   assign w_onehot  = NREQ'(1) << w_win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_rdata <= '0;
         r_busy  <= 1'b1;
      end else begin
         r_gnt <= '0;
         if (w_load) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
         end else begin
            case (r_state)
               FILL: begin
                  if (r_cnt == LAST) begin
                     r_state <= HOLD;
                     r_cnt   <= '0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               HOLD: begin
                  if (w_found) begin
                     r_state <= GRANT;
                     r_gnt   <= w_onehot;
                     r_rdata <= w_lfsr;
                     r_ptr   <= w_ptr_nxt;
                     r_busy  <= 1'b1;
                  end
               end
               GRANT: begin
                  if (STEPS == 1) begin
                     r_state <= HOLD;
                     r_cnt   <= '0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= FILL;
                     r_cnt   <= 8'd1;
                  end
               end
               default: begin
                  r_state <= FILL;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign gnt   = r_gnt;
   assign rdata = r_rdata;
   assign busy  = r_busy;

endmodule

// File: tb/tb_rng_sched.sv
// Self-checking bench for rng_sched: directed scenarios plus random traffic
// compared every cycle against an event-level delivery model.
module tb_rng_sched;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned STEPS = 4;
   localparam logic [7:0]  SEED  = 8'h0F;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [NREQ-1:0] req   = '0;
   logic [NREQ-1:0] gnt;
   logic [7:0]      rdata;
   logic            busy;
`ifdef RNG_SEED_LOAD_EN
   logic            seed_we = 1'b0;
   logic [7:0]      seed    = '0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   rng_sched #(
      .NREQ (NREQ),
      .STEPS(STEPS),
      .SEED (SEED)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .gnt  (gnt),
      .rdata(rdata),
      .busy (busy)
`ifdef RNG_SEED_LOAD_EN
      ,
      .seed_we(seed_we),
      .seed   (seed)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] adv(input logic [7:0] v, input int unsigned n);
      logic [7:0] x;
      x = v;
      for (int unsigned i = 0; i < n; i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
      return x;
   endfunction

   // Model: a value becomes claimable on the edge after m_ready; each delivery
   // or reload schedules the next one STEPS edges later.
   int              m_e;
   int              m_ready;
   int              m_ptr;
   logic [7:0]      m_val;
   logic [NREQ-1:0] m_gnt;
   logic [7:0]      m_rdata;
   logic            m_busy;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_e     = 0;
         m_ready = STEPS;
         m_ptr   = 0;
         m_val   = adv(SEED, STEPS);
         m_gnt   = '0;
         m_rdata = '0;
         m_busy  = 1'b1;
      end else begin
         m_e++;
         m_gnt = '0;
`ifdef RNG_SEED_LOAD_EN
         if (seed_we) begin
            m_val   = adv((seed == 8'h00) ? SEED : seed, STEPS);
            m_ready = m_e + STEPS;
         end else
`endif
         if (m_e > m_ready && req != '0) begin
            int w;
            w = -1;
            for (int k = 0; k < NREQ; k++)
               if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            m_gnt   = NREQ'(1) << w;
            m_rdata = m_val;
            m_ptr   = (w + 1) % NREQ;
            m_val   = adv(m_val, STEPS);
            m_ready = m_e + STEPS;
         end
         m_busy = (m_gnt != '0) || (m_e < m_ready);
      end
      #1;
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("busy", 32'(busy), 32'(m_busy));
   end

   task automatic wait_gnt(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (gnt != '0) begin
            ok = 1'b1;
            return;
         end
      end
      chk("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset(input logic [NREQ-1:0] r);
      @(negedge clk);
      rst_n = 1'b0;
      req   = r;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int idx_of(input logic [NREQ-1:0] g);
      for (int i = 0; i < NREQ; i++) if (g[i]) return i;
      return -1;
   endfunction

   initial begin
      bit         ok;
      int         exp_order[5];
      logic [7:0] vals[5];
      int         last_cyc;
      int         dup;
      int         idle;

      exp_order = '{0, 1, 2, 3, 0};
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);

      // First delivery after reset
      req   = 4'b0001;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("busy_e3", 32'(busy), 32'h1);
      @(posedge clk);
      #1 chk("busy_e4", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      chk("first_gnt", 32'(gnt), 32'h1);
      chk("first_rdata", 32'(rdata), 32'hFB);
      @(negedge clk) req = '0;

      // All requesting: rotation, spacing, uniqueness
      do_reset(4'b1111);
      last_cyc = 0;
      dup      = 0;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(20, ok);
         if (!ok) break;
         chk("rr_order", 32'(idx_of(gnt)), 32'(exp_order[i]));
         vals[i] = rdata;
         for (int j = 0; j < i; j++) if (vals[j] == rdata) dup++;
         if (i > 0) chk("gnt_spacing", 32'(cyc - last_cyc), 32'd5);
         last_cyc = cyc;
      end
      chk("rdata_unique", 32'(dup), 32'd0);
      chk("rr_first_val", 32'(vals[0]), 32'hFB);

      // Pointer wrap and idle behaviour
      do_reset(4'b1000);
      wait_gnt(20, ok);
      chk("wrap_g3", 32'(gnt), 32'h8);
      @(negedge clk) req = 4'b0100;
      wait_gnt(20, ok);
      chk("wrap_g2", 32'(gnt), 32'h4);
      @(negedge clk) req = '0;
      idle = 0;
      repeat (30) begin
         @(posedge clk);
         #1 if (gnt != '0) idle++;
      end
      chk("idle_gnts", 32'(idle), 32'd0);

      // Reset during GRANT
      do_reset(4'b0001);
      wait_gnt(20, ok);
      #2 rst_n = 1'b0;
      #1;
      chk("rstg_gnt", 32'(gnt), 32'h0);
      chk("rstg_rdata", 32'(rdata), 32'h0);
      chk("rstg_busy", 32'(busy), 32'h1);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      wait_gnt(20, ok);
      chk("rstg_next", 32'(rdata), 32'hFB);
      @(negedge clk) req = '0;

`ifdef RNG_SEED_LOAD_EN
      // Zero-seed reload in HOLD suppresses the grant
      do_reset('0);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk);
         #1 ok = (busy == 1'b0);
      end
      chk("hold_reached", 32'(ok), 32'd1);
      @(negedge clk);
      req     = 4'b0010;
      seed_we = 1'b1;
      seed    = 8'h00;
      @(negedge clk);
      seed_we = 1'b0;
      chk("seed_nogrant", 32'(gnt), 32'h0);
      chk("seed_busy", 32'(busy), 32'h1);
      wait_gnt(20, ok);
      chk("seed0_gnt", 32'(gnt), 32'h2);
      chk("seed0_rdata", 32'(rdata), 32'hFB);
      @(negedge clk) req = '0;

      // Reload mid-FILL
      do_reset('0);
      repeat (2) @(negedge clk);
      seed_we = 1'b1;
      seed    = 8'h1F;
      @(negedge clk);
      seed_we = 1'b0;
      req     = 4'b0001;
      wait_gnt(20, ok);
      chk("seed1f_rdata", 32'(rdata), 32'hF6);
      @(negedge clk) req = '0;
`endif

      // Random traffic against the model
      do_reset('0);
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         rst_n = 1'b1;
         req   = req & ~gnt;
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
         if ($urandom_range(0, 99) < 5) req = '0;
`ifdef RNG_SEED_LOAD_EN
         seed_we = ($urandom_range(0, 59) == 0);
         seed    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
`endif
         if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
`ifdef RNG_SEED_LOAD_EN
      seed_we = 1'b0;
`endif
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
